dmem_stream_reader: RTL



---
 rtl/dmem_stream_pkg.sv | 19 +
 rtl/dmem_addr_counter.sv | 40 ++++
 rtl/dmem_stream_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dmem_stream_pkg.sv
// Shared constants and the state type for the data-memory stream reader.
// Build option: DMEM_STREAM_CHECKSUM_EN adds a trailing XOR checksum beat.
package dmem_stream_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 32;

  // CSUM is always part of the encoding so the state width does not change
  // with the build option; it is unreachable when the checksum is disabled.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/dmem_addr_counter.sv
// Loadable, wrapping address register that drives the data-memory address.
// Load takes priority over increment; increment wraps naturally at 2**ADDR_W.
module dmem_addr_counter
  import dmem_stream_pkg::*;
#(
  parameter int AW = dmem_stream_pkg::ADDR_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  // Next address: load a new base, step by one, or hold.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (inc_i) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Address register, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/dmem_stream_reader.sv
// Read-side initiator for the 32 x 8 data memory: walks a wrap-around address
// range, reads each byte combinationally and streams it over valid/ready.
// Never writes the memory. Build option DMEM_STREAM_CHECKSUM_EN appends one
// beat carrying the XOR of all data bytes of the request.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; start with count 0 goes straight to DONE
// FETCH | capture memory read data into the output register
// SEND  | hold the beat until tx_ready, then advance address/remaining
// CSUM  | present the checksum beat (checksum build only)
// DONE  | one-cycle done pulse, then back to IDLE
module dmem_stream_reader #(
  parameter int ADDR_W = dmem_stream_pkg::ADDR_W,
  parameter int DATA_W = dmem_stream_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [ADDR_W-1:0] mem_address_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  import dmem_stream_pkg::*;

  state_e            state_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   remaining_q;
`ifdef DMEM_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  logic addr_load;
  logic addr_inc;

  // Address moves only on an accepted start or a data-beat handshake, so it
  // stays put while a beat waits for the sink.
  always_comb begin
    addr_load = (state_q == IDLE) && start_i && (count_i != '0);
    addr_inc  = (state_q == SEND) && tx_ready_i;
  end

  dmem_addr_counter #(
    .AW (ADDR_W)
  ) u_addr_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (addr_load),
    .load_addr_i (start_addr_i),
    .inc_i       (addr_inc),
    .addr_o      (mem_address_o)
  );

  // Sequencer with registered stream, busy and done outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
`ifdef DMEM_STREAM_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            if (count_i != '0) begin
              remaining_q <= count_i;
`ifdef DMEM_STREAM_CHECKSUM_EN
              csum_q      <= '0;
`endif
              state_q     <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        FETCH: begin
          // Registering the byte here decouples the beat from later memory writes.
          tx_data_q  <= mem_data_i;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end

        SEND: begin
          if (tx_ready_i) begin
            tx_valid_q  <= 1'b0;
            remaining_q <= remaining_q - 1'b1;
`ifdef DMEM_STREAM_CHECKSUM_EN
            csum_q      <= csum_q ^ tx_data_q;
`endif
            if (remaining_q == (ADDR_W+1)'(1)) begin
`ifdef DMEM_STREAM_CHECKSUM_EN
              state_q <= CSUM;
`else
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              state_q <= FETCH;
            end
          end
        end

`ifdef DMEM_STREAM_CHECKSUM_EN
        CSUM: begin
          // First cycle loads the finished checksum, then it is held like a data beat.
          if (!tx_valid_q) begin
            tx_data_q  <= csum_q;
            tx_valid_q <= 1'b1;
          end else if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
`endif

        DONE: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
